// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type and fetch-side constants for the fetch queue
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;
  localparam logic [31:0] RESET_PC  = 32'h00003000;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode circular buffer with flush; FETCH_QUEUE_BYPASS_EN adds empty-queue bypass
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_instr,
  output logic          out_misalign,
  output logic [CW-1:0] count,
  output logic          pc_hold
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  fetch_entry_t in_ent, head;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic bypass_sel, push, pop;
  assign in_ent = '{pc: in_pc, instr: in_instr, misalign: |in_pc[1:0]};
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_sel = (cnt == '0) & in_valid;
`else
  assign bypass_sel = 1'b0;
`endif
  assign head         = bypass_sel ? in_ent : mem[rp];
  assign in_ready     = cnt != CW'(DEPTH);
  assign pc_hold      = ~in_ready;
  assign out_valid    = ((cnt != '0) | bypass_sel) & ~flush;
  assign push         = in_valid & in_ready & ~flush & ~(bypass_sel & out_ready);
  assign pop          = out_valid & out_ready & ~bypass_sel;
  assign out_pc       = head.pc;
  assign out_pc4      = head.pc + 32'd4;
  assign out_instr    = head.instr;
  assign out_misalign = head.misalign;
  assign count        = cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: '0, instr: NOP_INSTR, misalign: 1'b0};
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= in_ent;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  logic clock = 0, reset, flush, in_valid, in_ready, out_valid, out_ready, out_misalign, pc_hold;
  logic [31:0] in_pc, in_instr, out_pc, out_pc4, out_instr;
  logic [CW-1:0] count;
  ent_t exp_q[$];
  int tests = 0, fails = 0, cnt_now = 0;
  bit armed = 0, skip = 1;
  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc4(out_pc4),
    .out_instr(out_instr), .out_misalign(out_misalign), .count(count), .pc_hold(pc_hold)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic r, input logic fl, input logic rs);
    @(posedge clock);
    #1;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = r; flush = fl; reset = rs;
    cnt_now = exp_q.size();
    skip = rs;
    if (rs || fl) exp_q.delete();
    else if (v && cnt_now != DEPTH) exp_q.push_back('{pc, ins});
  endtask
  task automatic drain();
    repeat (DEPTH + 2) cyc(0, 0, 0, 1, 0, 0);
  endtask
  always @(negedge clock) begin
    if (armed && !skip) begin
      automatic bit ev = (cnt_now != 0 || (BYP && in_valid)) && !flush;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(cnt_now != DEPTH));
      chk("pc_hold", 32'(pc_hold), 32'(cnt_now == DEPTH));
      chk("count", 32'(count), 32'(cnt_now));
      if (ev) begin
        if (exp_q.size() == 0) chk("scoreboard_nonempty", 32'd0, 32'd1);
        else begin
          automatic ent_t e = exp_q[0];
          chk("out_pc", out_pc, e.pc);
          chk("out_pc4", out_pc4, e.pc + 32'd4);
          chk("out_instr", out_instr, e.ins);
          chk("out_misalign", 32'(out_misalign), 32'(e.pc[1:0] != 2'b00));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_instr = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    armed = 1;
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h4);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_misalign", 32'(out_misalign), 32'h0);
    cyc(1, 32'h3000, 32'h11, 0, 0, 0);
    cyc(1, 32'h3004, 32'h22, 0, 0, 0);
    cyc(1, 32'h3008, 32'h33, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h5000 + 32'(i * 4), 32'(i), 0, 0, 0);
    cyc(1, 32'h5010, 32'd4, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    drain();
    cyc(1, 32'h6000, 32'hA0, 0, 0, 0);
    cyc(1, 32'h6004, 32'hA1, 0, 0, 0);
    for (int i = 2; i < 22; i++) cyc(1, 32'h6000 + 32'(i * 4), 32'hA0 + 32'(i), 1, 0, 0);
    drain();
    for (int i = 0; i < 3; i++) cyc(1, 32'h7000 + 32'(i * 4), 32'hB0 + 32'(i), 0, 0, 0);
    cyc(1, 32'h4000, 32'hC0, 1, 1, 0);
    cyc(1, 32'h4000, 32'hC0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h3002, 32'hD0, 0, 0, 0);
    cyc(1, 32'h3004, 32'hD1, 0, 0, 0);
    drain();
    cyc(1, 32'h3000, 32'hE0, 1, 0, 0);
    drain();
    for (int i = 0; i < 2; i++) cyc(1, 32'h8000 + 32'(i * 4), 32'(i), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      automatic logic [31:0] p = $urandom;
      if ($urandom_range(3) != 0) p[1:0] = 2'b00;
      cyc($urandom_range(9) < 7, p, $urandom, $urandom_range(9) < 6,
          $urandom_range(19) == 0, $urandom_range(49) == 0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
